// File: rtl/rgb_to_gray_pipe_if.sv
// Pixel stream bundle for rgb_to_gray_pipe: RGB input side and gray output side.
// Handshake rule, both sides: a beat transfers on a rising edge where valid & ready;
// valid and its payload stay stable until that edge, and ready may depend on the other side.
interface rgb_to_gray_pipe_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_rgb;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_gray;
  logic        m_last;

  modport master (
    output s_valid, s_rgb, s_last, m_ready,
    input  s_ready, m_valid, m_gray, m_last
  );

  modport slave (
    input  s_valid, s_rgb, s_last, m_ready,
    output s_ready, m_valid, m_gray, m_last
  );
endinterface

// File: rtl/rgb_to_gray_pipe.sv
// Three-stage RGB to gray converter (77/150/29 luma weights) with a whole-pipe stall
// and an output-side frame length checker.
module rgb_to_gray_pipe #(
  parameter bit ROUND        = 1'b0,
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 19
) (
  input  logic                clk,
  input  logic                rst,
  rgb_to_gray_pipe_if.slave   pix,
  output logic                frame_done,
  output logic                len_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [15:0]      RND      = ROUND ? 16'd128 : 16'd0;

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [15:0]      pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic             l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
  logic [15:0]      acc_q, acc_d;
  logic [7:0]       gray_q, gray_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fd_q, fd_d, err_q, err_d;

  logic        adv, out_hs, at_end;
  logic [15:0] r16, g16, b16;

  // Every stage moves together; only a stalled valid output blocks the pipe.
  assign adv    = ~v3_q | pix.m_ready;
  assign out_hs = v3_q & pix.m_ready;
  assign at_end = (cnt_q == LAST_IDX);

  assign r16 = {8'd0, pix.s_rgb[23:16]};
  assign g16 = {8'd0, pix.s_rgb[15:8]};
  assign b16 = {8'd0, pix.s_rgb[7:0]};

  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    pr_d   = pr_q;
    pg_d   = pg_q;
    pb_d   = pb_q;
    l1_d   = l1_q;
    l2_d   = l2_q;
    l3_d   = l3_q;
    acc_d  = acc_q;
    gray_d = gray_q;
    if (adv) begin
      v1_d = pix.s_valid;
      if (pix.s_valid) begin
        pr_d = (r16 << 6) + (r16 << 3) + (r16 << 2) + r16;
        pg_d = (g16 << 7) + (g16 << 4) + (g16 << 2) + (g16 << 1);
        pb_d = (b16 << 4) + (b16 << 3) + (b16 << 2) + b16;
        l1_d = pix.s_last;
      end
      v2_d   = v1_q;
      acc_d  = pr_q + pg_q + pb_q + RND;
      l2_d   = l1_q;
      v3_d   = v2_q;
      gray_d = acc_q[15:8];
      l3_d   = l2_q;
    end
  end

  // A frame ends either at the expected count or at a last marker; disagreement is an error.
  always_comb begin
    cnt_d = cnt_q;
    fd_d  = 1'b0;
    err_d = err_q;
    if (out_hs) begin
      cnt_d = (at_end || l3_q) ? '0 : cnt_q + CNT_W'(1);
      fd_d  = at_end;
      err_d = err_q | (at_end != l3_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      l1_q   <= 1'b0;
      l2_q   <= 1'b0;
      l3_q   <= 1'b0;
      acc_q  <= '0;
      gray_q <= '0;
      cnt_q  <= '0;
      fd_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      pr_q   <= pr_d;
      pg_q   <= pg_d;
      pb_q   <= pb_d;
      l1_q   <= l1_d;
      l2_q   <= l2_d;
      l3_q   <= l3_d;
      acc_q  <= acc_d;
      gray_q <= gray_d;
      cnt_q  <= cnt_d;
      fd_q   <= fd_d;
      err_q  <= err_d;
    end
  end

  assign pix.s_ready = adv;
  assign pix.m_valid = v3_q;
  assign pix.m_gray  = gray_q;
  assign pix.m_last  = l3_q;
  assign frame_done  = fd_q;
  assign len_err     = err_q;

endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Bench for rgb_to_gray_pipe: a truncating and a rounding instance (4-pixel frames)
// driven with identical stimulus.
module tb_rgb_to_gray_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_to_gray_pipe_if if0 ();
  rgb_to_gray_pipe_if if1 ();
  logic fd0, le0, fd1, le1;

  rgb_to_gray_pipe #(.ROUND(1'b0), .FRAME_PIXELS(4), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .pix(if0), .frame_done(fd0), .len_err(le0)
  );
  rgb_to_gray_pipe #(.ROUND(1'b1), .FRAME_PIXELS(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .pix(if1), .frame_done(fd1), .len_err(le1)
  );

  typedef struct {
    logic [23:0] rgb;
    logic [7:0]  g_trunc;
    logic [7:0]  g_round;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int fd_at[$];
  int le_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [23:0] rgb, input logic last, input logic mr);
    if0.s_valid = v;  if1.s_valid = v;
    if0.s_rgb   = rgb; if1.s_rgb  = rgb;
    if0.s_last  = last; if1.s_last = last;
    if0.m_ready = mr; if1.m_ready = mr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] luma(input logic [23:0] p, input bit rnd);
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]) + (rnd ? 128 : 0);
    return 8'(s >> 8);
  endfunction

  function automatic logic [23:0] pix_of(input int i);
    logic [7:0] r, g, b;
    r = 8'(i * 37 + 11);
    g = 8'(i * 91 + 5);
    b = 8'(i * 53 + 200);
    return {r, g, b};
  endfunction

  task automatic do_reset;
    drive(1'b0, 24'd0, 1'b0, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_valid0"}, {31'd0, if0.m_valid}, 0);
    check({tag, "_m_valid1"}, {31'd0, if1.m_valid}, 0);
    check({tag, "_m_gray0"},  {24'd0, if0.m_gray}, 0);
    check({tag, "_m_gray1"},  {24'd0, if1.m_gray}, 0);
    check({tag, "_m_last0"},  {31'd0, if0.m_last}, 0);
    check({tag, "_frame_done"}, {30'd0, fd0, fd1}, 0);
    check({tag, "_len_err"},  {30'd0, le0, le1}, 0);
    check({tag, "_s_ready"},  {30'd0, if0.s_ready, if1.s_ready}, 32'd3);
  endtask

  // One pixel with m_ready held high: check the 3-cycle latency and both results.
  task automatic send_single(input vec_t v);
    drive(1'b1, v.rgb, 1'b0, 1'b1);
    tick;
    drive(1'b0, 24'd0, 1'b0, 1'b1);
    check("lat_c1_valid", {31'd0, if0.m_valid}, 0);
    tick;
    check("lat_c2_valid", {31'd0, if0.m_valid}, 0);
    tick;
    check("lat_c3_valid", {30'd0, if0.m_valid, if1.m_valid}, 32'd3);
    check("gray_trunc", {24'd0, if0.m_gray}, {24'd0, v.g_trunc});
    check("gray_round", {24'd0, if1.m_gray}, {24'd0, v.g_round});
    tick;
    check("drained_valid", {31'd0, if0.m_valid}, 0);
  endtask

  // Streams n model-generated pixels; m_ready is 1,0,0,1 repeating when toggle is set.
  // Records handshake counts at which frame_done is seen and when len_err first rises.
  task automatic run_stream(input int n, input logic [31:0] last_mask, input bit toggle,
                            input int base);
    logic [16:0] exp_q[$];
    logic [16:0] e;
    logic [23:0] px;
    logic [7:0]  held0, held1;
    logic        mr, lst;
    bit          hold;
    int          sent, got, hs, cyc, tail;
    sent = 0; got = 0; hs = 0; cyc = 0; tail = 0; hold = 0;
    held0 = '0; held1 = '0;
    fd_at.delete();
    le_at = -1;
    while (tail < 3 && cyc < 400) begin
      mr  = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      px  = pix_of(base + sent);
      lst = (sent < 32) ? last_mask[sent] : 1'b0;
      drive(sent < n, px, lst, mr);
      #1;
      if (fd0 === 1'b1 || fd1 === 1'b1) fd_at.push_back(hs + ((fd0 !== fd1) ? 1000 : 0));
      if (le_at < 0 && (le0 === 1'b1 || le1 === 1'b1)) le_at = hs + ((le0 !== le1) ? 1000 : 0);
      if (hold) begin
        check("stall_valid", {30'd0, if0.m_valid, if1.m_valid}, 32'd3);
        check("stall_gray0", {24'd0, if0.m_gray}, {24'd0, held0});
        check("stall_gray1", {24'd0, if1.m_gray}, {24'd0, held1});
      end
      if (if0.m_valid && !mr)
        check("s_ready_stalled", {30'd0, if0.s_ready, if1.s_ready}, 0);
      else
        check("s_ready_free", {30'd0, if0.s_ready, if1.s_ready}, 32'd3);
      hold  = if0.m_valid && !mr;
      held0 = if0.m_gray;
      held1 = if1.m_gray;
      if (if0.m_valid && mr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_gray0", {24'd0, if0.m_gray}, {24'd0, e[15:8]});
          check("stream_gray1", {24'd0, if1.m_gray}, {24'd0, e[7:0]});
          check("stream_last",  {30'd0, if0.m_last, if1.m_last}, {30'd0, e[16], e[16]});
          check("stream_valid1", {31'd0, if1.m_valid}, 32'd1);
        end
        got++;
        hs++;
      end
      if (sent < n && if0.s_ready) begin
        exp_q.push_back({lst, luma(px, 1'b0), luma(px, 1'b1)});
        sent++;
      end
      if (got >= n) tail++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("stream_count", got, n);
    check("stream_queue_empty", exp_q.size(), 0);
    drive(1'b0, 24'd0, 1'b0, 1'b1);
  endtask

  task automatic check_fd(input string tag, input int e0, input int e1, input int cnt);
    check({tag, "_fd_count"}, fd_at.size(), cnt);
    if (cnt > 0) check({tag, "_fd_first"}, (fd_at.size() > 0) ? fd_at[0] : -1, e0);
    if (cnt > 1) check({tag, "_fd_second"}, (fd_at.size() > 1) ? fd_at[1] : -1, e1);
  endtask

  initial begin
    vec_t vecs[10];
    vecs[0] = '{24'hFFFFFF, 8'd255, 8'd255};
    vecs[1] = '{24'hFF0000, 8'd76,  8'd77};
    vecs[2] = '{24'h00FF00, 8'd149, 8'd149};
    vecs[3] = '{24'h0000FF, 8'd28,  8'd29};
    vecs[4] = '{24'h000000, 8'd0,   8'd0};
    vecs[5] = '{24'h808080, 8'd128, 8'd128};
    vecs[6] = '{24'h123456, 8'd45,  8'd46};
    vecs[7] = '{24'h010101, 8'd1,   8'd1};
    vecs[8] = '{24'h7F7F7F, 8'd127, 8'd127};
    vecs[9] = '{24'h000080, 8'd14,  8'd15};

    rst = 1'b1;
    drive(1'b0, 24'd0, 1'b0, 1'b1);
    tick;
    check_idle_outputs("reset");
    rst = 1'b0;
    tick;

    for (int i = 0; i < 10; i++) send_single(vecs[i]);

    // Ordering and stall behaviour under the 1,0,0,1 m_ready pattern.
    do_reset;
    run_stream(16, 32'h0, 1'b1, 100);

    // Two well-formed frames.
    do_reset;
    run_stream(8, 32'h88, 1'b1, 0);
    check_fd("frames_ok", 4, 8, 2);
    check("frames_ok_len_err", le_at, -1);

    // Short frame (last on pixel 3) followed by a correct 4-pixel frame.
    do_reset;
    run_stream(7, 32'h44, 1'b0, 200);
    check_fd("short_frame", 7, 0, 1);
    check("short_frame_err_at", le_at, 3);
    check("short_frame_err_sticky", {30'd0, le0, le1}, 32'd3);

    // Reset while two pixels are held in a stalled pipe.
    do_reset;
    drive(1'b1, 24'hFF0000, 1'b0, 1'b0);
    tick;
    drive(1'b1, 24'h0000FF, 1'b0, 1'b0);
    tick;
    drive(1'b0, 24'd0, 1'b0, 1'b0);
    tick;
    check("stall_pre_valid", {30'd0, if0.m_valid, if1.m_valid}, 32'd3);
    check("stall_pre_gray", {24'd0, if0.m_gray}, 32'd76);
    tick;
    check("stall_hold_gray", {24'd0, if1.m_gray}, 32'd77);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    tick;
    rst = 1'b0;
    drive(1'b0, 24'd0, 1'b0, 1'b1);
    tick;
    run_stream(4, 32'h8, 1'b1, 50);
    check_fd("post_reset", 4, 0, 1);
    check("post_reset_len_err", le_at, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_to_gray_pipe.md
Name: rgb_to_gray_pipe

Overview:
- Streaming pixel stage directly upstream of the grayscale adder datapath.
- Accepts 24-bit RGB pixels on a valid/ready interface and applies the luma weights 77/150/29 (sum 256) using shift-and-add partial products.
- Reduces the weighted terms through a 3-stage pipeline and emits an 8-bit gray pixel with backpressure support.
- Tracks pixels per frame and flags frame-length mismatches against the input last marker.

Parameters:
- ROUND, 0: 1 adds 128 before the final >>8 (round half up); 0 truncates.
- FRAME_PIXELS, 307200: expected pixels per frame (640x480); must be >= 1.
- CNT_W, 19: width of the output pixel counter; must satisfy 2^CNT_W >= FRAME_PIXELS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  input pixel valid.
- s_ready  output  1  stage can accept an input pixel.
- s_rgb  input  24  pixel: [23:16] R, [15:8] G, [7:0] B.
- s_last  input  1  marks the final pixel of a frame.
- m_valid  output  1  output gray pixel valid.
- m_ready  input  1  downstream accepts the output pixel.
- m_gray  output  8  gray value.
- m_last  output  1  s_last delayed, aligned with m_gray.
- frame_done  output  1  one-cycle pulse when the pixel completing a frame is accepted at the output.
- len_err  output  1  sticky flag: frame length mismatch; cleared only by rst.

Behaviour:
- Reset (asynchronous, rst=1): every pipeline valid bit and data register = 0; counter = 0; m_valid=0, m_gray=0, m_last=0, frame_done=0, len_err=0. s_ready=1 while rst=0 and the pipeline is empty.
- Global advance: adv = ~m_valid | m_ready. s_ready = adv (combinational from m_valid/m_ready only; no dependency on s_valid).
- When adv=1, all three stages shift on the clock edge. A stage's valid bit loads from the previous stage's valid bit; the input stage loads s_valid & s_ready.
- When adv=0, all stage registers hold. m_gray, m_last and m_valid stay stable until accepted.
- Stage 1 registers 16-bit partial sums:
  - pr = (R<<6)+(R<<3)+(R<<2)+R
  - pg = (G<<7)+(G<<4)+(G<<2)+(G<<1)
  - pb = (B<<4)+(B<<3)+(B<<2)+B
  - s_last is carried alongside.
- Stage 2 registers acc = pr+pg+pb (+128 if ROUND=1), 16 bits. Maximum is 65408, so there is no overflow.
- Stage 3 registers m_gray = acc[15:8] and m_last. The result is always <= 255; no saturation is needed.
- Latency: 3 cycles from input acceptance to m_valid when m_ready=1 throughout. Throughput is 1 pixel/clk. Pixel order is preserved. No pixel is dropped or duplicated under any m_ready pattern.
- Frame counter increments on each output handshake (m_valid & m_ready).
  - Handshake with cnt == FRAME_PIXELS-1: frame_done=1 on the next cycle and cnt returns to 0.
  - Handshake with m_last=1 and cnt != FRAME_PIXELS-1: len_err set, cnt returns to 0, no frame_done.
  - Handshake with cnt == FRAME_PIXELS-1 and m_last=0: len_err set, frame_done still pulses, cnt returns to 0.
  - Handshake with cnt == FRAME_PIXELS-1 and m_last=1: normal frame completion, no error.
- Bubbles (s_valid=0 while adv=1) propagate as invalid stages. They never count and never assert m_valid.
- Asserting rst mid-frame or mid-stall discards all in-flight pixels immediately. The first pixel after reset release starts a new frame at cnt=0.
- s_rgb is sampled only on an input handshake. Its value while s_valid=0 is don't-care.

Test Plan:
- Single pixel, m_ready=1, ROUND=0:
  - s_rgb=FFFFFF -> m_gray=255, m_valid high exactly 3 cycles after acceptance.
  - FF0000 -> 76; 00FF00 -> 149; 0000FF -> 28; 000000 -> 0.
- ROUND=1: FF0000 -> 77; 0000FF -> 29; 808080 (acc 32768+128) -> 128.
- Back-to-back stream of 16 pixels with m_ready toggling 1,0,0,1 repeating -> 16 outputs in order, values matching the model. m_gray stays stable while m_valid=1 and m_ready=0. s_ready=0 exactly while m_valid=1 and m_ready=0.
- FRAME_PIXELS=4, 8 pixels with s_last on pixels 4 and 8 -> frame_done pulses on the cycle after the 4th and the 8th output handshakes; len_err stays 0.
- FRAME_PIXELS=4 with s_last on pixel 3 -> len_err=1 after the 3rd output handshake and stays 1. The next 4 pixels then produce frame_done after their 4th handshake.
- Assert rst for 1 cycle with 2 pixels in flight and m_ready=0 -> m_valid=0 immediately and all outputs are 0. After release, the next 4-pixel frame completes with frame_done and no len_err.
